multdiv_unit: RTL and testbench
===============================

# multdiv_unit

Iterative signed 32-bit multiply/divide unit that sits beside the ALU in the execute stage and handles the MUL/DIV opcodes, which the single-cycle ALU does not implement. It accepts a one-cycle start pulse with two operands. After a fixed multi-cycle latency it returns a 32-bit result, an exception flag, and a one-cycle ready strobe. The pipeline stalls on it until the strobe fires.

## Interface
Parameters:
- none (width fixed at 32, iteration count fixed at 32)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset; sampled on clock rising edge
- data_operandA  in  32  dividend / multiplicand, two's complement
- data_operandB  in  32  divisor / multiplier, two's complement
- ctrl_MULT  in  1  start-multiply pulse
- ctrl_DIV  in  1  start-divide pulse
- data_result  out  32  product (low 32 bits) or quotient
- data_exception  out  1  overflow or divide-by-zero
- data_resultRDY  out  1  one-cycle result-valid strobe

## Operation
- Reset: state IDLE; data_result=0, data_exception=0, data_resultRDY=0. Reset dominates any start on the same edge.
- States:
  - IDLE.
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - FIX: sign/exception resolve, 1 cycle.
  - DONE: RDY high, 1 cycle, then IDLE.
- Start:
  - ctrl_MULT or ctrl_DIV high at a rising edge starts an operation and latches both operands on that edge.
  - Later operand changes are ignored.
  - If both are high, MULT wins.
- Restart: a start in any non-IDLE state aborts the current operation and restarts with the new operands. No RDY is issued for the aborted operation.
- Multiply:
  - Radix-2 Booth, 64-bit accumulator.
  - Result = product[31:0].
  - Exception = 1 when product[63:31] is not all-equal, i.e. the result does not fit in signed 32 bits.
- Divide:
  - Unsigned non-restoring division on the operand magnitudes. Quotient negated when signA XOR signB. Truncates toward zero; remainder discarded.
  - B==0: result 0, exception 1.
  - A=0x80000000, B=0xFFFFFFFF: result 0x80000000, exception 1.
  - These two cases still take full latency.
- Outputs:
  - data_result and data_exception update on the edge that raises RDY.
  - They hold until the next operation's RDY edge or reset. A start does not clear them.

## Timing
- Start sampled on edge E0. Iterations on E1..E32, FIX on E33, RDY raised on E34 and dropped on E35.
- Latency from start edge to RDY = 34 cycles, identical for MUL, DIV and the exception cases.
- A start on the same edge that RDY falls (E35) is legal. Back-to-back throughput is one operation per 35 cycles.
- A start during DONE is legal. RDY still drops on the next edge and the new operation proceeds.
- Reset mid-operation: IDLE next cycle, no RDY, outputs cleared.

## Configuration
- MULTDIV_DIV_EN defined: division datapath compiled in, behaviour as above.
- MULTDIV_DIV_EN undefined:
  - Divider logic is removed.
  - ctrl_DIV still starts an operation with the same 34-cycle latency.
  - Result is 0 and data_exception is 1.
  - Multiply is unaffected.

## Structure
- Package multdiv_pkg:
  - state encoding (IDLE, MUL, DIV, FIX, DONE).
  - ITER_COUNT=32, LATENCY=34.
  - INT_MIN constant 0x80000000.
- One sub-module, multdiv_counter: 6-bit synchronous counter.
  - Inputs: clear (start or reset) and enable (MUL/DIV states).
  - Output: terminal flag at ITER_COUNT.
- Add/subtract steps use the existing 32-bit carry-select adder (adder_csel), instantiated once and shared between MUL and DIV.

## Test plan
1. MULT A=7, B=0xFFFFFFFD (-3) -> RDY exactly 34 cycles after start; result 0xFFFFFFEB; exception 0.
2. MULT A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1. Repeat with A=0xFFFFFFFF, B=0xFFFFFFFF -> result 1, exception 0.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> result 0xFFFFFFFD, exception 0. Then A=100, B=0xFFFFFFF6 -> result 0xFFFFFFF6.
4. DIV A=5, B=0 -> result 0, exception 1. DIV A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1. Both with RDY at 34 cycles.
5. MULT start, then DIV A=9, B=3 start 10 cycles later -> exactly one RDY pulse, 34 cycles after the DIV start, result 3.
6. MULT start, then reset on cycle 20 -> no RDY within 60 cycles; outputs 0. Also: ctrl_MULT and ctrl_DIV together with A=6, B=2 -> result 12.

Source files
------------

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared types and constants for the iterative multiply/divide
//                unit: FSM state encoding, iteration count, end-to-end
//                latency and the signed 32-bit minimum value.
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int          ITER_COUNT = 32;
    localparam int          LATENCY    = 34;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    // Unsigned magnitude of a two's complement word; INT_MIN maps to 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] value);
        return value[31] ? (~value + 32'd1) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_csel.sv
`default_nettype none
// ============================================================================
//  Module      : adder_csel
//  Description : 32-bit carry-select adder. The upper half is evaluated for
//                both carry-in values and selected by the lower-half carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_csel (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [16:0] low_sum;
    logic [16:0] high_sum0;
    logic [16:0] high_sum1;

    assign low_sum   = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    assign high_sum0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign high_sum1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

    assign sum  = {low_sum[16] ? high_sum1[15:0] : high_sum0[15:0], low_sum[15:0]};
    assign cout = low_sum[16] ? high_sum1[16] : high_sum0[16];

endmodule
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_counter
//  Description : 6-bit iteration counter. Cleared on start or reset, counts
//                while enabled, flags terminal once ITER_COUNT steps are done.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [5:0] count;

    // Iteration count: clear has priority over enable.
    always_ff @(posedge clock) begin
        if (clear) begin
            count <= 6'd0;
        end else if (enable) begin
            count <= count + 6'd1;
        end
    end

    assign terminal = (count == 6'(ITER_COUNT));

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_unit
//  Description : Iterative signed 32-bit multiply (radix-2 Booth) and divide
//                (non-restoring on magnitudes) with a fixed 34-cycle latency
//                and a one-cycle result-ready strobe. One shared adder.
//                Macro MULTDIV_DIV_EN compiles in the divider datapath; without
//                it a divide returns result 0 with the exception flag set.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    state_t      state;
    logic [31:0] hi;        // Booth accumulator high word / partial remainder
    logic [31:0] lo;        // multiplier, then product low word / quotient
    logic [31:0] addend;    // multiplicand or divisor magnitude
    logic        q_1;       // Booth look-behind bit
    logic        is_div;
`ifdef MULTDIV_DIV_EN
    logic        rem_sign;  // bit 32 of the partial remainder
    logic        quot_neg;
    logic        div_zero;
    logic        div_ovf;
`endif

    logic        start;
    logic        iter_en;
    logic        iter_done;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cin;
    logic        add_cout;
    logic        add_top;
    logic        booth_add;
    logic        booth_sub;
    logic [32:0] booth_hi;
    logic [32:0] prod_top;
    logic [31:0] fix_result;
    logic        fix_exc;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign iter_en = ((state == MUL) || (state == DIV)) && !iter_done;

    multdiv_counter u_counter (
        .clock    (clock),
        .clear    (reset | start),
        .enable   (iter_en),
        .terminal (iter_done)
    );

    // Booth pair 01 adds the multiplicand, 10 subtracts it.
    assign booth_add = lo[0] ^ q_1;
    assign booth_sub = lo[0] & ~q_1;

    // Shared adder operand selection for the Booth step or the division step.
    always_comb begin
        add_a   = hi;
        add_b   = booth_sub ? ~addend : addend;
        add_cin = booth_sub;
`ifdef MULTDIV_DIV_EN
        if (state == DIV) begin
            add_a   = {hi[30:0], lo[31]};
            add_b   = rem_sign ? addend : ~addend;
            add_cin = ~rem_sign;
        end
`endif
    end

    adder_csel u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Bit 32 of the sign-extended 33-bit sum, so the shift never loses sign.
`ifdef MULTDIV_DIV_EN
    assign add_top = (state == DIV) ? (hi[31] ^ ~rem_sign ^ add_cout)
                                    : (add_a[31] ^ add_b[31] ^ add_cout);
`else
    assign add_top = add_a[31] ^ add_b[31] ^ add_cout;
`endif

    assign booth_hi = booth_add ? {add_top, add_sum} : {hi[31], hi};
    assign prod_top = {hi, lo[31]};

    // Sign correction and exception resolution of the finished operation.
    always_comb begin
        fix_result = lo;
        fix_exc    = !((&prod_top) || !(|prod_top));
        if (is_div) begin
`ifdef MULTDIV_DIV_EN
            if (div_zero) begin
                fix_result = 32'd0;
                fix_exc    = 1'b1;
            end else if (div_ovf) begin
                fix_result = INT_MIN;
                fix_exc    = 1'b1;
            end else begin
                fix_result = quot_neg ? (~lo + 32'd1) : lo;
                fix_exc    = 1'b0;
            end
`else
            fix_result = 32'd0;
            fix_exc    = 1'b1;
`endif
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            hi             <= 32'd0;
            lo             <= 32'd0;
            addend         <= 32'd0;
            q_1            <= 1'b0;
            is_div         <= 1'b0;
`ifdef MULTDIV_DIV_EN
            rem_sign       <= 1'b0;
            quot_neg       <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
`endif
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                // A start in any state (re)loads operands; MULT has priority.
                hi     <= 32'd0;
                q_1    <= 1'b0;
                is_div <= !ctrl_MULT;
                if (ctrl_MULT) begin
                    state  <= MUL;
                    lo     <= data_operandB;
                    addend <= data_operandA;
                end else begin
                    state  <= DIV;
`ifdef MULTDIV_DIV_EN
                    lo       <= magnitude(data_operandA);
                    addend   <= magnitude(data_operandB);
                    rem_sign <= 1'b0;
                    quot_neg <= data_operandA[31] ^ data_operandB[31];
                    div_zero <= (data_operandB == 32'd0);
                    div_ovf  <= (data_operandA == INT_MIN) && (&data_operandB);
`else
                    lo     <= 32'd0;
                    addend <= 32'd0;
`endif
                end
            end else begin
                case (state)
                    MUL: begin
                        if (iter_done) begin
                            state <= FIX;
                        end else begin
                            hi  <= booth_hi[32:1];
                            lo  <= {booth_hi[0], lo[31:1]};
                            q_1 <= lo[0];
                        end
                    end
                    DIV: begin
                        if (iter_done) begin
                            state <= FIX;
                        end else begin
`ifdef MULTDIV_DIV_EN
                            rem_sign <= add_top;
                            hi       <= add_sum;
                            lo       <= {lo[30:0], ~add_top};
`endif
                        end
                    end
                    FIX: begin
                        data_result    <= fix_result;
                        data_exception <= fix_exc;
                        data_resultRDY <= 1'b1;
                        state          <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_unit
//  Description : Directed self-checking bench for multdiv_unit. Expected
//                divide results depend on MULTDIV_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int          checks;
    int          errors;
    logic [31:0] last_res;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue a one-cycle start; returns #1 after the start edge with operands scrambled.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = ~a;
        data_operandB = b ^ 32'h5A5A_0F0F;
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int lat;
        start_op(m, d, a, b);
        check({tag, "_rdy_low"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, "_held"}, data_result, last_res);
        lat = 0;
        while (lat < 100 && !data_resultRDY) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd34);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        last_res = exp_res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        checks        = 0;
        errors        = 0;
        last_res      = 32'd0;
        reset         = 1'b1;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Multiplies, issued back-to-back on the edge RDY falls.
        run_op("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("mul_m1xm1", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("mul_min_x1", 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
        run_op("mul_min_xm1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Divides.
        run_op("div_m7d2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,
               DIV_EN ? 32'hFFFF_FFFD : 32'd0, !DIV_EN);
        run_op("div_100dm10", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6,
               DIV_EN ? 32'hFFFF_FFF6 : 32'd0, !DIV_EN);
        run_op("div_big", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd7,
               DIV_EN ? 32'h1249_2492 : 32'd0, !DIV_EN);
        run_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
        run_op("div_minm1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               DIV_EN ? 32'h8000_0000 : 32'd0, 1'b1);

        // Restart: MULT aborted by a DIV ten cycles later.
        start_op(1'b1, 1'b0, 32'd100, 32'd3);
        repeat (9) @(posedge clock);
        run_op("restart_div", 1'b0, 1'b1, 32'd9, 32'd3,
               DIV_EN ? 32'd3 : 32'd0, !DIV_EN);
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        check("restart_extra_rdy", pulses, 32'd0);

        // Reset in the middle of a multiply.
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exc", {31'd0, data_exception}, 32'd0);
        last_res = 32'd0;
        pulses = 0;
        repeat (60) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        check("midreset_no_rdy", pulses, 32'd0);
        check("midreset_result_after", data_result, 32'd0);

        // Both start pulses together: multiply wins.
        run_op("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd2, 32'd12, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
